// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode constants, state encoding, default word width.
// Imported by both the SPI master and the SPI slave.
package spi_pkg;

    localparam logic SPI_CPOL       = 1'b0;
    localparam logic SPI_CPHA       = 1'b1;
    localparam int   SPI_DATA_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEL  = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one SPI pin plus a history flop.
// Rise and fall are decoded from the last synchroniser stage and the history flop.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {STAGES{RST_VAL}};
            hist <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            hist <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;

endmodule

// File: rtl/spi_slave_m1.sv
// SPI slave, CPOL=0 / CPHA=1, MSB first, all pins oversampled on sysclk.
// MISO is driven on the SCK rise; MOSI is captured on the SCK fall.
module spi_slave_m1
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  spi_sck,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_load,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sck_rise, sck_fall;
    logic cs_rise, cs_fall;
    logic mosi_lvl;
    logic sck_lvl_unused, cs_lvl_unused;
    logic mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk   (sysclk),
        .rst   (rst),
        .din   (spi_sck),
        .level (sck_lvl_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // cs_n idles high, so a falling edge is a select and a rising edge a deselect
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk   (sysclk),
        .rst   (rst),
        .din   (spi_cs_n),
        .level (cs_lvl_unused),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk   (sysclk),
        .rst   (rst),
        .din   (spi_mosi),
        .level (mosi_lvl),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    spi_state_e state, state_nxt;

    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_nxt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  word_done;
    logic                  miso_q;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (cs_fall) state_nxt = ST_SEL;
            ST_SEL:  if (cs_rise) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        spi_miso_oe = 1'b0;
        spi_miso    = 1'b0;
        if (state == ST_SEL) begin
            busy        = 1'b1;
            spi_miso_oe = 1'b1;
            spi_miso    = miso_q;
        end
    end

    // A final fall that coincides with deselect still completes the word
    always_comb begin
        word_done = sck_fall && (bit_cnt == LAST_BIT);
        rx_nxt    = {rx_shift[DATA_WIDTH-2:0], mosi_lvl};
        cnt_nxt   = bit_cnt;
        if (word_done) begin
            cnt_nxt = '0;
        end else if (sck_fall) begin
            cnt_nxt = bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            bit_cnt   <= '0;
            miso_q    <= 1'b0;
            tx_load   <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            tx_load   <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (state == ST_IDLE) begin
                if (cs_fall) begin
                    tx_shift <= tx_data;
                    tx_load  <= 1'b1;
                    rx_shift <= '0;
                    bit_cnt  <= '0;
                    miso_q   <= 1'b0;
                end
            end else begin
                if (sck_rise) begin
                    miso_q   <= tx_shift[DATA_WIDTH-1];
                    tx_shift <= tx_shift << 1;
                end
                if (sck_fall) begin
                    rx_shift <= rx_nxt;
                    bit_cnt  <= cnt_nxt;
                end
                if (word_done) begin
                    rx_data  <= rx_nxt;
                    rx_valid <= 1'b1;
                    tx_shift <= tx_data;
                    tx_load  <= 1'b1;
                end
                if (cs_rise) begin
                    frame_err <= (cnt_nxt != '0);
                    bit_cnt   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_m1.sv
// Bench for spi_slave_m1: a CPHA=1 master model drives the pins, a
// monitor checks every rx_valid against a queue of expected words.
module tb_spi_slave_m1;

    logic       sysclk = 1'b0;
    logic       rst;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;

    always #5 sysclk = ~sysclk;

    spi_slave_m1 #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_rxv = 0;
    int cnt_ferr = 0;
    int cnt_load = 0;
    int busy_drop = 0;
    logic [7:0] rx_exp[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge sysclk) begin
        if (rx_valid === 1'b1) begin
            cnt_rxv++;
            if (rx_exp.size() == 0) begin
                check("rx_valid_unexpected", 32'd1, 32'd0);
            end else begin
                check("rx_word", {24'd0, rx_data}, {24'd0, rx_exp.pop_front()});
            end
        end
        if (frame_err === 1'b1) cnt_ferr++;
        if (tx_load === 1'b1) cnt_load++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits,
                        input int half, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_sck  = 1'b1;
            spi_mosi = tx[7-i];
            cyc(half);
            spi_sck   = 1'b0;
            rx[7-i]   = spi_miso;
            if (busy !== 1'b1) busy_drop++;
            cyc(half);
        end
    endtask

    task automatic cs_low(input int half);
        spi_cs_n = 1'b0;
        cyc(half);
    endtask

    task automatic cs_high(input int half);
        spi_cs_n = 1'b1;
        cyc(2 * half + 4);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r0, r1;
        logic [7:0] cur, nxt, d;
        int v0, l0, f0, b0, idle_bad;

        rst = 1'b1;
        spi_sck = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tx_data = 8'h00;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_flags",
              {26'd0, rx_valid, tx_load, busy, frame_err, spi_miso, spi_miso_oe},
              32'd0);

        // single word
        tx_data = 8'h5C;
        rx_exp.push_back(8'hA3);
        v0 = cnt_rxv; l0 = cnt_load;
        cs_low(5);
        xfer(8'hA3, 8, 5, r0);
        cs_high(5);
        check("t1_master_rx", {24'd0, r0}, 32'h5C);
        check("t1_rx_valid_cnt", cnt_rxv - v0, 32'd1);
        check("t1_tx_load_cnt", cnt_load - l0, 32'd2);
        check("t1_rx_data", {24'd0, rx_data}, 32'hA3);

        // two back-to-back words
        tx_data = 8'h5C;
        rx_exp.push_back(8'h12);
        rx_exp.push_back(8'hF0);
        v0 = cnt_rxv; l0 = cnt_load; b0 = busy_drop;
        cs_low(5);
        tx_data = 8'h81;
        xfer(8'h12, 8, 5, r0);
        xfer(8'hF0, 8, 5, r1);
        cs_high(5);
        check("t2_master_rx0", {24'd0, r0}, 32'h5C);
        check("t2_master_rx1", {24'd0, r1}, 32'h81);
        check("t2_rx_valid_cnt", cnt_rxv - v0, 32'd2);
        check("t2_tx_load_cnt", cnt_load - l0, 32'd3);
        check("t2_busy_held", busy_drop - b0, 32'd0);

        // aborted frame then clean frame
        v0 = cnt_rxv; f0 = cnt_ferr;
        cs_low(5);
        xfer(8'hFF, 5, 5, r0);
        cs_high(5);
        check("t3_frame_err_cnt", cnt_ferr - f0, 32'd1);
        check("t3_no_rx_valid", cnt_rxv - v0, 32'd0);
        check("t3_rx_data_held", {24'd0, rx_data}, 32'hF0);
        tx_data = 8'hC3;
        rx_exp.push_back(8'h3C);
        cs_low(5);
        xfer(8'h3C, 8, 5, r0);
        cs_high(5);
        check("t3_master_rx", {24'd0, r0}, 32'hC3);
        check("t3_rx_data", {24'd0, rx_data}, 32'h3C);

        // reset mid-word
        v0 = cnt_rxv; f0 = cnt_ferr;
        tx_data = 8'h6A;
        cs_low(5);
        xfer(8'h55, 4, 5, r0);
        rst = 1'b1;
        spi_cs_n = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("t4_rx_data_cleared", {24'd0, rx_data}, 32'd0);
        check("t4_flags_cleared",
              {26'd0, rx_valid, tx_load, busy, frame_err, spi_miso, spi_miso_oe},
              32'd0);
        cyc(20);
        check("t4_no_frame_err", cnt_ferr - f0, 32'd0);
        check("t4_no_rx_valid", cnt_rxv - v0, 32'd0);
        rx_exp.push_back(8'h96);
        cs_low(5);
        xfer(8'h96, 8, 5, r0);
        cs_high(5);
        check("t4_master_rx", {24'd0, r0}, 32'h6A);
        check("t4_rx_data", {24'd0, rx_data}, 32'h96);

        // SCK toggling while deselected
        v0 = cnt_rxv; l0 = cnt_load; idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            spi_sck = 1'b1;
            spi_mosi = i[0];
            cyc(4);
            if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0 || busy !== 1'b0)
                idle_bad++;
            spi_sck = 1'b0;
            cyc(4);
        end
        check("t5_idle_pins", idle_bad, 32'd0);
        check("t5_no_rx_valid", cnt_rxv - v0, 32'd0);
        check("t5_no_tx_load", cnt_load - l0, 32'd0);

        // minimum SCK half period, 16 frames of 16 random words
        v0 = cnt_rxv; f0 = cnt_ferr;
        for (int f = 0; f < 16; f++) begin
            cur = 8'($urandom_range(0, 255));
            tx_data = cur;
            cs_low(4);
            for (int w = 0; w < 16; w++) begin
                nxt = 8'($urandom_range(0, 255));
                tx_data = nxt;
                d = 8'($urandom_range(0, 255));
                rx_exp.push_back(d);
                xfer(d, 8, 4, r0);
                check("t6_master_rx", {24'd0, r0}, {24'd0, cur});
                cur = nxt;
            end
            cs_high(4);
        end
        check("t6_rx_valid_cnt", cnt_rxv - v0, 32'd256);
        check("t6_no_frame_err", cnt_ferr - f0, 32'd0);

        cyc(10);
        check("scoreboard_empty", rx_exp.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
